// File: rtl/ksa_add_scheduler.sv
//============================================================================
// Module  : ksa_add_scheduler
// Brief   : Round-robin time-sharing of one gate-level Kogge-Stone adder.
//           Optional capture-time self-check under `KSA_SCHED_CHECK_EN`.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module ksa_add_scheduler #(
    parameter int WIDTH         = 16,
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ-1:0]       cin_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      sum_out,
    output logic                  cout_out,
    output logic                  busy,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  err
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_done;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic [WIDTH-1:0]     r_add_a;
    logic [WIDTH-1:0]     r_add_b;
    logic                 r_add_cin;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_win;
    logic                 w_capture;

    // Scan from lowest to highest priority so the last hit (offset 0 = ptr) wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                w_found = 1'b1;
                w_win   = c_PTR_W'(idx);
            end
        end
    end

    assign w_capture = (r_state == SETTLE) && (r_cnt == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found)   w_next_state = SETTLE;
            SETTLE:  if (w_capture) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            if (r_state == IDLE && w_found) begin
                r_add_a      <= a_in[w_win*WIDTH +: WIDTH];
                r_add_b      <= b_in[w_win*WIDTH +: WIDTH];
                r_add_cin    <= cin_in[w_win];
                r_gnt[w_win] <= 1'b1;
                r_owner      <= w_win;
                r_cnt        <= c_CNT_W'(SETTLE_CYCLES - 1);
            end else if (r_state == SETTLE) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end else begin
                    r_sum           <= add_sum;
                    r_cout          <= add_cout;
                    r_done[r_owner] <= 1'b1;
                    r_ptr           <= (r_owner == c_PTR_W'(NREQ - 1)) ? '0
                                                                       : r_owner + c_PTR_W'(1);
                end
            end
        end
    end

`ifdef KSA_SCHED_CHECK_EN
    logic [WIDTH:0] w_ref;
    logic           r_err;

    assign w_ref = {1'b0, r_add_a} + {1'b0, r_add_b} + {{WIDTH{1'b0}}, r_add_cin};

    // Sticky: once the gate-level adder disagrees, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)                                            r_err <= 1'b0;
        else if (w_capture && ({add_cout, add_sum} != w_ref)) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign sum_out  = r_sum;
    assign cout_out = r_cout;
    assign busy     = (r_state == SETTLE);
    assign add_a    = r_add_a;
    assign add_b    = r_add_b;
    assign add_cin  = r_add_cin;

endmodule

`default_nettype wire

// File: tb/tb_ksa_add_scheduler.sv
//============================================================================
// Module  : tb_ksa_add_scheduler
// Brief   : Scoreboard bench for ksa_add_scheduler with a behavioural adder.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ksa_add_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [3:0]  cin_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] sum_out;
    logic        cout_out;
    logic        busy;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        err;
    logic        inject;
    logic [16:0] w_full;

    typedef struct {
        int          id;
        logic [16:0] res;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    ksa_add_scheduler #(.WIDTH(16), .NREQ(4), .SETTLE_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .gnt(gnt), .done(done), .sum_out(sum_out), .cout_out(cout_out), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .err(err)
    );

    // Behavioural stand-in for the gate-level adder, with an optional LSB fault.
    assign w_full   = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
    assign add_sum  = w_full[15:0] ^ {15'b0, inject};
    assign add_cout = w_full[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [16:0] calc(input logic [15:0] a, input logic [15:0] b,
                                         input logic c);
        return {1'b0, a} + {1'b0, b} + {16'b0, c};
    endfunction

    task automatic issue(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input bit push);
        exp_t e;
        req[r]           = 1'b1;
        a_in[r*16 +: 16] = a;
        b_in[r*16 +: 16] = b;
        cin_in[r]        = c;
        if (push) begin
            e.id  = r;
            e.res = calc(a, b, c);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done == 4'b0 && cyc < 50);
        if (done == 4'b0) cyc = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0; cin_in = '0; inject = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (done !== 4'b0) begin bad++; $display("FAIL reset_done: got %b want 0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({cout_out, sum_out} !== 17'h0) begin bad++; $display("FAIL reset_sum: got %h want 0", {cout_out, sum_out}); end
        total++; if ({add_cin, add_a, add_b} !== 33'h0) begin bad++; $display("FAIL reset_add: got %h want 0", {add_cin, add_a, add_b}); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int   cyc;
        exp_t e;
        issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        total++; if (add_a !== 16'hFFFF) begin bad++; $display("FAIL single_add_a: got %h want ffff", add_a); end
        req = '0;
        wait_done(cyc);
        total++; if (cyc !== 3) begin bad++; $display("FAIL single_latency: got %0d want 3", cyc); end
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL single_done: got %b want 0100", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop: got %b want 0", busy); end
        if (sb.size() == 0) begin total++; bad++; $display("FAIL single_sb: got empty want entry"); end
        else begin
            e = sb.pop_front();
            total++; if ({cout_out, sum_out} !== e.res) begin bad++; $display("FAIL single_sum: got %h want %h", {cout_out, sum_out}, e.res); end
        end
    endtask

    task automatic test_fairness;
        int   order [5] = '{0, 1, 2, 3, 0};
        int   ng, nd, last_g;
        exp_t e;
        logic [3:0] oh;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req[i]           = 1'b1;
            a_in[i*16 +: 16] = 16'h1111 * 16'(i + 1);
            b_in[i*16 +: 16] = 16'h0F0F + 16'(i);
            cin_in[i]        = 1'(i);
        end
        for (int k = 0; k < 5; k++) begin
            e.id  = order[k];
            e.res = calc(a_in[order[k]*16 +: 16], b_in[order[k]*16 +: 16], cin_in[order[k]]);
            sb.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        ng = 0; nd = 0; last_g = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                oh = (ng < 5) ? (4'b1 << order[ng]) : 4'b0;
                total++; if (gnt !== oh) begin bad++; $display("FAIL fair_order%0d: got %b want %b", ng, gnt, oh); end
                if (ng > 0) begin
                    total++; if (cyc - last_g !== 4) begin bad++; $display("FAIL fair_spacing%0d: got %0d want 4", ng, cyc - last_g); end
                end
                last_g = cyc;
                ng++;
            end
            if (done != 4'b0) begin
                if (sb.size() == 0) begin total++; bad++; $display("FAIL fair_sb: got empty want entry"); end
                else begin
                    e  = sb.pop_front();
                    oh = 4'b1 << e.id;
                    total++; if (done !== oh) begin bad++; $display("FAIL fair_done%0d: got %b want %b", nd, done, oh); end
                    total++; if ({cout_out, sum_out} !== e.res) begin bad++; $display("FAIL fair_sum%0d: got %h want %h", nd, {cout_out, sum_out}, e.res); end
                end
                nd++;
                if (nd == 5) begin
                    req = '0;
                    break;
                end
            end
        end
        total++; if (nd !== 5) begin bad++; $display("FAIL fair_count: got %0d want 5", nd); end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_idle: got %b want 0", busy); end
    endtask

    task automatic test_late;
        int   c, g_early, cyc;
        exp_t e;
        issue(3, 16'h1234, 16'h4321, 1'b1, 1'b1);
        @(negedge clk);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL late_gnt3: got %b want 1000", gnt); end
        req = '0;
        @(negedge clk);
        issue(1, 16'hA5A5, 16'h5A5B, 1'b0, 1'b1);
        c = 0; g_early = 0;
        do begin
            @(negedge clk);
            c++;
            if (gnt != 4'b0) g_early++;
        end while (done == 4'b0 && c < 20);
        total++; if (g_early !== 0) begin bad++; $display("FAIL late_gnt_busy: got %0d want 0", g_early); end
        total++; if (done !== 4'b1000) begin bad++; $display("FAIL late_done3: got %b want 1000", done); end
        e = sb.pop_front();
        total++; if ({cout_out, sum_out} !== e.res) begin bad++; $display("FAIL late_sum3: got %h want %h", {cout_out, sum_out}, e.res); end
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL late_gnt1: got %b want 0010", gnt); end
        req = '0;
        wait_done(cyc);
        total++; if (done !== 4'b0010) begin bad++; $display("FAIL late_done1: got %b want 0010", done); end
        e = sb.pop_front();
        total++; if ({cout_out, sum_out} !== e.res) begin bad++; $display("FAIL late_sum1: got %h want %h", {cout_out, sum_out}, e.res); end
    endtask

    task automatic test_reset_mid;
        int   nd, cyc;
        exp_t e;
        issue(2, 16'h0F0F, 16'h0101, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rmid_gnt: got %b want 0100", gnt); end
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if ({gnt, done, busy, err} !== 10'h0) begin bad++; $display("FAIL rmid_ctrl: got %h want 0", {gnt, done, busy, err}); end
        total++; if ({cout_out, sum_out} !== 17'h0) begin bad++; $display("FAIL rmid_sum: got %h want 0", {cout_out, sum_out}); end
        total++; if ({add_cin, add_a, add_b} !== 33'h0) begin bad++; $display("FAIL rmid_add: got %h want 0", {add_cin, add_a, add_b}); end
        rst = 1'b0;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done != 4'b0) nd++;
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL rmid_no_done: got %0d want 0", nd); end
        issue(1, 16'h0003, 16'h0004, 1'b0, 1'b1);
        issue(3, 16'h0030, 16'h0040, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rmid_ptr: got %b want 0010", gnt); end
        req = '0;
        wait_done(cyc);
        total++; if (done !== 4'b0010) begin bad++; $display("FAIL rmid_done: got %b want 0010", done); end
        e = sb.pop_front();
        total++; if ({cout_out, sum_out} !== e.res) begin bad++; $display("FAIL rmid_sum2: got %h want %h", {cout_out, sum_out}, e.res); end
    endtask

    task automatic test_carry;
        int   cyc;
        exp_t e;
        issue(0, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
        @(negedge clk);
        req = '0;
        wait_done(cyc);
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL carry_done: got %b want 0001", done); end
        e = sb.pop_front();
        total++; if ({cout_out, sum_out} !== e.res) begin bad++; $display("FAIL carry_sum: got %h want %h", {cout_out, sum_out}, e.res); end
        repeat (5) @(negedge clk);
        total++; if ({cout_out, sum_out} !== 17'h10000) begin bad++; $display("FAIL carry_hold: got %h want 10000", {cout_out, sum_out}); end
        total++; if ({add_cin, add_a, add_b} !== {1'b1, 16'h7FFF, 16'h8000}) begin bad++; $display("FAIL carry_add_hold: got %h want %h", {add_cin, add_a, add_b}, {1'b1, 16'h7FFF, 16'h8000}); end
    endtask

    task automatic test_back_to_back;
        int   r, cyc;
        exp_t e;
        logic [3:0] oh;
        for (int n = 0; n < 8; n++) begin
            r = $urandom_range(0, 3);
            issue(r, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            oh = 4'b1 << r;
            @(negedge clk);
            total++; if (gnt !== oh) begin bad++; $display("FAIL b2b_gnt%0d: got %b want %b", n, gnt, oh); end
            req = '0;
            wait_done(cyc);
            total++; if (cyc !== 3) begin bad++; $display("FAIL b2b_latency%0d: got %0d want 3", n, cyc); end
            e = sb.pop_front();
            total++; if (done !== (4'b1 << e.id)) begin bad++; $display("FAIL b2b_done%0d: got %b want %b", n, done, 4'b1 << e.id); end
            total++; if ({cout_out, sum_out} !== e.res) begin bad++; $display("FAIL b2b_sum%0d: got %h want %h", n, {cout_out, sum_out}, e.res); end
        end
    endtask

    task automatic test_err;
        int   cyc;
        logic exp_err;
`ifdef KSA_SCHED_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        inject = 1'b1;
        issue(2, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early: got %b want 0", err); end
        req = '0;
        wait_done(cyc);
        total++; if (sum_out !== 16'h2344) begin bad++; $display("FAIL err_sum: got %h want 2344", sum_out); end
        total++; if (err !== exp_err) begin bad++; $display("FAIL err_done: got %b want %b", err, exp_err); end
        inject = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (err !== exp_err) begin bad++; $display("FAIL err_sticky: got %b want %b", err, exp_err); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        req    = '0;
        a_in   = '0;
        b_in   = '0;
        cin_in = '0;
        inject = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_late();
        test_reset_mid();
        test_carry();
        test_back_to_back();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
